// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the IF-stage branch predictor.
// Holds the 2-bit counter encoding, the conditional-branch opcodes
// and the saturating counter helpers used by the training path.
package branch_predictor_pkg;

   typedef logic [1:0] cnt_t;

   // 2-bit saturating counter states; bit 1 set means "predict taken"
   localparam cnt_t SNT = 2'b00;
   localparam cnt_t WNT = 2'b01;
   localparam cnt_t WT  = 2'b10;
   localparam cnt_t ST  = 2'b11;

   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;

   function automatic cnt_t sat_inc(input cnt_t c);
      return (c == ST) ? ST : cnt_t'(c + 2'd1);
   endfunction

   function automatic cnt_t sat_dec(input cnt_t c);
      return (c == SNT) ? SNT : cnt_t'(c - 2'd1);
   endfunction

   function automatic logic is_cond_branch(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
             (op == OP_BGTZ) || (op == OP_REGIMM);
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Signal bundle between the pipeline (fetch + ID branch resolver) and the
// branch predictor.
//   master : pipeline side, drives IF lookup and ID resolve, receives
//            prediction / mispredict / recovery PC
//   slave  : predictor side
interface branch_predictor_if;

   logic [31:0] IF_PC;
   logic [5:0]  IF_op;
   logic        PCWrite;
   logic        ID_Flush;
   logic        ID_resolve;
   logic [31:0] ID_PC;
   logic        ID_taken;
   logic [31:0] ID_target;

   logic        predict_taken;
   logic [31:0] predict_target;
   logic        ID_predicted;
   logic        mispredict;
   logic [31:0] recover_PC;

   modport master (
      output IF_PC, IF_op, PCWrite, ID_Flush, ID_resolve, ID_PC, ID_taken, ID_target,
      input  predict_taken, predict_target, ID_predicted, mispredict, recover_PC
   );

   modport slave (
      input  IF_PC, IF_op, PCWrite, ID_Flush, ID_resolve, ID_PC, ID_taken, ID_target,
      output predict_taken, predict_target, ID_predicted, mispredict, recover_PC
   );

endinterface

// File: rtl/branch_pred_table.sv
// Direct-mapped BTB storage: valid, tag, 2-bit counter and target per entry.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   rd_idx / rd_*         : combinational read for the IF lookup
//   up_idx / up_*         : combinational read of the entry being trained
//   we, wr_idx, wr_*      : synchronous write; a write always marks the entry valid
// Reset clears valid and loads INIT_CNT into every counter; tag and target
// storage is left unreset. Reset takes priority over a write in the same cycle.
module branch_pred_table
   import branch_predictor_pkg::*;
#(
   parameter int   ENTRIES  = 16,
   parameter cnt_t INIT_CNT = WNT,
   localparam int  IDX      = $clog2(ENTRIES),
   localparam int  TAGW     = 30 - IDX
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [IDX-1:0]  rd_idx,
   output logic            rd_valid,
   output logic [TAGW-1:0] rd_tag,
   output cnt_t            rd_cnt,
   output logic [31:0]     rd_target,
   input  logic [IDX-1:0]  up_idx,
   output logic            up_valid,
   output logic [TAGW-1:0] up_tag,
   output cnt_t            up_cnt,
   output logic [31:0]     up_target,
   input  logic            we,
   input  logic [IDX-1:0]  wr_idx,
   input  logic [TAGW-1:0] wr_tag,
   input  cnt_t            wr_cnt,
   input  logic [31:0]     wr_target
);

   logic            valid_q  [ENTRIES];
   logic            valid_d  [ENTRIES];
   cnt_t            cnt_q    [ENTRIES];
   cnt_t            cnt_d    [ENTRIES];
   logic [TAGW-1:0] tag_q    [ENTRIES];
   logic [TAGW-1:0] tag_d    [ENTRIES];
   logic [31:0]     target_q [ENTRIES];
   logic [31:0]     target_d [ENTRIES];

   // Reads see the registered state only, so a same-cycle write is not bypassed.
   always_comb begin
      rd_valid  = valid_q[rd_idx];
      rd_tag    = tag_q[rd_idx];
      rd_cnt    = cnt_q[rd_idx];
      rd_target = target_q[rd_idx];
      up_valid  = valid_q[up_idx];
      up_tag    = tag_q[up_idx];
      up_cnt    = cnt_q[up_idx];
      up_target = target_q[up_idx];
   end

   always_comb begin
      valid_d  = valid_q;
      cnt_d    = cnt_q;
      tag_d    = tag_q;
      target_d = target_q;
      if (we) begin
         valid_d[wr_idx]  = 1'b1;
         cnt_d[wr_idx]    = wr_cnt;
         tag_d[wr_idx]    = wr_tag;
         target_d[wr_idx] = wr_target;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '{default: 1'b0};
         cnt_q   <= '{default: INIT_CNT};
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   // Tag and target are only meaningful behind a valid bit; a write attempted
   // under reset is harmless because the entry comes out of reset invalid.
   always_ff @(posedge clock) begin
      tag_q    <= tag_d;
      target_q <= target_d;
   end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: direct-mapped BTB with 2-bit counters.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bp (slave)   : IF lookup (IF_PC, IF_op), pipeline control (PCWrite,
//                  ID_Flush), ID resolve (ID_resolve, ID_PC, ID_taken,
//                  ID_target); outputs predict_taken/predict_target,
//                  ID_predicted, mispredict, recover_PC
// Prediction is combinational from IF_PC/IF_op. Training happens at the
// clock edge on ID_resolve && PCWrite and is visible the cycle after.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int   ENTRIES  = 16,
   parameter cnt_t INIT_CNT = WNT
) (
   input logic               clock,
   input logic               reset,
   branch_predictor_if.slave bp
);

   localparam int IDX  = $clog2(ENTRIES);
   localparam int TAGW = 30 - IDX;

   logic [IDX-1:0]  rd_idx;
   logic [TAGW-1:0] rd_tag_pc;
   logic            rd_valid;
   logic [TAGW-1:0] rd_tag;
   cnt_t            rd_cnt;
   logic [31:0]     rd_target;

   logic [IDX-1:0]  up_idx;
   logic [TAGW-1:0] up_tag_pc;
   logic            up_valid;
   logic [TAGW-1:0] up_tag;
   cnt_t            up_cnt;
   logic [31:0]     up_target;

   logic            we;
   cnt_t            wr_cnt;
   logic [31:0]     wr_target;

   logic            upd_fire;
   logic            up_hit;
   logic            id_predicted_d;
   logic            id_predicted_q;

   assign rd_idx    = bp.IF_PC[IDX+1:2];
   assign rd_tag_pc = bp.IF_PC[31:IDX+2];
   assign up_idx    = bp.ID_PC[IDX+1:2];
   assign up_tag_pc = bp.ID_PC[31:IDX+2];

   branch_pred_table #(
      .ENTRIES  (ENTRIES),
      .INIT_CNT (INIT_CNT)
   ) u_table (
      .clock     (clock),
      .reset     (reset),
      .rd_idx    (rd_idx),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_cnt    (rd_cnt),
      .rd_target (rd_target),
      .up_idx    (up_idx),
      .up_valid  (up_valid),
      .up_tag    (up_tag),
      .up_cnt    (up_cnt),
      .up_target (up_target),
      .we        (we),
      .wr_idx    (up_idx),
      .wr_tag    (up_tag_pc),
      .wr_cnt    (wr_cnt),
      .wr_target (wr_target)
   );

   always_comb begin
      bp.predict_taken  = is_cond_branch(bp.IF_op) && rd_valid &&
                          (rd_tag == rd_tag_pc) && rd_cnt[1];
      bp.predict_target = bp.predict_taken ? rd_target : bp.IF_PC + 32'd4;
   end

   // Training: a hit adjusts the counter (and refreshes the target when taken);
   // a taken miss allocates as weakly taken; a not-taken miss leaves the table alone.
   always_comb begin
      upd_fire  = bp.ID_resolve && bp.PCWrite;
      up_hit    = up_valid && (up_tag == up_tag_pc);
      we        = 1'b0;
      wr_cnt    = up_cnt;
      wr_target = up_target;
      if (upd_fire) begin
         if (up_hit) begin
            we = 1'b1;
            if (bp.ID_taken) begin
               wr_cnt    = sat_inc(up_cnt);
               wr_target = bp.ID_target;
            end else begin
               wr_cnt    = sat_dec(up_cnt);
            end
         end else if (bp.ID_taken) begin
            we        = 1'b1;
            wr_cnt    = WT;
            wr_target = bp.ID_target;
         end
      end
   end

   // Flush wins even while stalled so a squashed slot never carries a prediction.
   always_comb begin
      id_predicted_d = id_predicted_q;
      if (bp.ID_Flush) begin
         id_predicted_d = 1'b0;
      end else if (bp.PCWrite) begin
         id_predicted_d = bp.predict_taken;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         id_predicted_q <= 1'b0;
      end else begin
         id_predicted_q <= id_predicted_d;
      end
   end

   always_comb begin
      bp.ID_predicted = id_predicted_q;
      bp.mispredict   = upd_fire && (bp.ID_taken != id_predicted_q);
      bp.recover_PC   = bp.ID_taken ? bp.ID_target : bp.ID_PC + 32'd4;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

IF-stage dynamic branch predictor: a direct-mapped branch target buffer with 2-bit saturating counters. Each cycle it tells the fetch unit whether the conditional branch now being fetched is predicted taken, and where to fetch next. It receives the actual outcome from the ID-stage branch resolver a cycle later, trains its table, and raises a mispredict with the correct recovery PC. It works opposite the ID branch test: this block issues predictions, the ID block resolves them.

## Interface
- ENTRIES, 16, table depth; power of two, 4..256; IDX = log2(ENTRIES)
- INIT_CNT, 2'b01, counter value written on reset (weakly not-taken)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- IF_PC  in  32  PC of the instruction in IF
- IF_op  in  6  opcode field of the instruction in IF
- PCWrite  in  1  pipeline advance enable; 0 = stall
- ID_Flush  in  1  squash the IF→ID prediction register (from jump or mispredict)
- ID_resolve  in  1  ID holds a conditional branch whose outcome is valid this cycle
- ID_PC  in  32  PC of that branch
- ID_taken  in  1  actual outcome
- ID_target  in  32  branch target, PC+4+(sext(offset)<<2)
- predict_taken  out  1  fetch redirect request for IF_PC
- predict_target  out  32  next-fetch PC when predict_taken=1
- ID_predicted  out  1  prediction that travelled with the instruction now in ID
- mispredict  out  1  ID outcome differs from ID_predicted
- recover_PC  out  32  correct next PC on mispredict

## Operation
- IF_branch = IF_op ∈ {000100, 000101, 000110, 000111, 000001}.
- Index = PC[IDX+1:2]; tag = PC[31:IDX+2]. Each entry holds valid, tag, 2-bit cnt, and a 32-bit target.
- predict_taken = IF_branch && valid[i] && tag match && cnt[1]. This is combinational. predict_target = target[i]. When predict_taken=0, predict_target is IF_PC+4.
- ID_predicted register: when PCWrite=1 it loads predict_taken, or loads 0 if ID_Flush=1. When PCWrite=0 it holds, and ID_Flush still clears it.
- mispredict = ID_resolve && PCWrite && (ID_taken != ID_predicted). It is combinational.
- recover_PC = ID_taken ? ID_target : ID_PC+4.
- Update fires on ID_resolve && PCWrite, at index/tag from ID_PC:
  - Hit, taken: cnt saturating increment (max 11); target is rewritten.
  - Hit, not taken: cnt saturating decrement (min 00).
  - Miss, taken: allocate or overwrite. valid=1, tag written, cnt=2'b10, target=ID_target.
  - Miss, not taken: no write.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.

## Timing
- Prediction has zero-cycle latency from IF_PC and IF_op. The update becomes visible on the cycle after the edge.
- Read and update to the same index in the same cycle: the read returns the pre-update value. There is no bypass.
- Reset at the edge clears all valid bits, sets every cnt to INIT_CNT, and clears ID_predicted. The tag and target arrays are not required to reset.
- Reset outputs: predict_taken=0, ID_predicted=0, mispredict=0 (when ID_resolve=0).
- Reset asserted mid-update: reset wins and no update is written.
- Stall (PCWrite=0): no table write, no mispredict, ID_predicted held.
- ID_Flush together with PCWrite=1: ID_predicted=0 the next cycle, whatever the prediction was.

## Structure
- Shared package: the counter constants SNT/WNT/WT/ST, the branch opcode constants, and a sat_inc/sat_dec function.
- One natural sub-module is branch_pred_table. It holds the storage arrays, with one combinational read port and one synchronous write port. Hit detection and the counter update stay in the top level.

## Test plan
- Reset, then fetch beq at 0x00400010 → predict_taken=0, predict_target=0x00400014. Next cycle ID_resolve=1, ID_taken=1, ID_target=0x00400040 → mispredict=1, recover_PC=0x00400040, entry allocated with cnt=10.
- Refetch the same PC → predict_taken=1, predict_target=0x00400040. Resolve taken → mispredict=0, cnt=11.
- Two not-taken resolves from cnt=11: the first gives cnt=10 and still predicts taken; the second gives cnt=01 and predicts not taken. Each not-taken resolve after a taken prediction gives mispredict=1, recover_PC=ID_PC+4.
- Aliasing, ENTRIES=16: PCs 0x00400010 and 0x00400050 share an index with different tags → a lookup with the wrong tag misses; a taken resolve of the second PC overwrites the entry.
- PCWrite=0 with ID_resolve=1, ID_taken≠ID_predicted → mispredict=0, no table change, ID_predicted held. ID_Flush=1 during the stall clears ID_predicted.
- Same-cycle read/update on one index: the IF lookup returns the old cnt, and the new cnt is seen the following cycle. Reset asserted during an update → all entries invalid the next cycle.
